// File: rtl/led_code_pkg.sv
// Shared definitions for the LED blink-code indicator: FSM state encoding
// and the width helper used to size the phase timer.
package led_code_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t ON   = 2'd1;
    localparam state_t OFF  = 2'd2;
    localparam state_t GAP  = 2'd3;

    // Bits needed for a down-counter that must hold the longest phase length.
    function automatic int timer_width(input int on_cyc, input int off_cyc, input int gap_cyc);
        int longest;
        longest = on_cyc;
        if (off_cyc > longest) longest = off_cyc;
        if (gap_cyc > longest) longest = gap_cyc;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/cyc_timer.sv
// Loadable down-counter that holds at zero; zero flag reflects the registered count.
module cyc_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/led_blink_code.sv
// Turns a numeric code into N LED flashes followed by a dark pause, with a
// start/busy/done handshake. Define LED_BLINK_CODE_REPEAT_EN to add the
// repeat_req input (named so because "repeat" is a reserved word).
module led_blink_code
    import led_code_pkg::*;
#(
    parameter int CODE_W  = 4,
    parameter int ON_CYC  = 12_500_000,
    parameter int OFF_CYC = 12_500_000,
    parameter int GAP_CYC = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CODE_W-1:0] code,
`ifdef LED_BLINK_CODE_REPEAT_EN
    input  logic              repeat_req,
`endif
    output logic              busy,
    output logic              done,
    output logic              led
);

    localparam int TIMER_W = timer_width(ON_CYC, OFF_CYC, GAP_CYC);

    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYC - 1);
    localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYC - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYC - 1);

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   remaining_q, remaining_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                led_q, led_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rpt;
    logic                timer_load;
    logic [TIMER_W-1:0]  timer_load_val;
    logic                timer_zero;

`ifdef LED_BLINK_CODE_REPEAT_EN
    assign rpt = repeat_req;
`else
    assign rpt = 1'b0;
`endif

    cyc_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_load_val),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            code_q      <= '0;
            led_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            code_q      <= code_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Remaining is decremented on leaving ON, so OFF sees the count still owed.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        code_d      = code_q;
        case (state_q)
            IDLE: begin
                if (start && (code != '0)) begin
                    state_d     = ON;
                    remaining_d = code;
                    code_d      = code;
                end
            end
            ON: begin
                if (timer_zero) begin
                    state_d     = OFF;
                    remaining_d = remaining_q - CODE_W'(1);
                end
            end
            OFF: begin
                if (timer_zero) begin
                    state_d = (remaining_q != '0) ? ON : GAP;
                end
            end
            GAP: begin
                if (timer_zero) begin
                    if (rpt) begin
                        state_d     = ON;
                        remaining_d = code_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next state so the registered copies line up with it.
    always_comb begin
        led_d          = (state_d == ON);
        busy_d         = (state_d != IDLE);
        done_d         = ((state_q == IDLE) && start && (code == '0)) ||
                         ((state_q == GAP) && (state_d == IDLE));
        timer_load     = (state_d != state_q);
        timer_load_val = '0;
        case (state_d)
            ON:      timer_load_val = ON_LOAD;
            OFF:     timer_load_val = OFF_LOAD;
            GAP:     timer_load_val = GAP_LOAD;
            default: timer_load_val = '0;
        endcase
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_led_blink_code.sv
// Self-checking bench for led_blink_code: a hand-derived vector table, a few
// directed multi-cycle sequences, and randomized traffic against a cycle-offset model.
module tb_led_blink_code;

   localparam int CODE_W  = 4;
   localparam int ON_CYC  = 4;
   localparam int OFF_CYC = 3;
   localparam int GAP_CYC = 10;
   localparam int PERIOD  = ON_CYC + OFF_CYC;
`ifdef LED_BLINK_CODE_REPEAT_EN
   localparam bit REPEAT_ON = 1'b1;
`else
   localparam bit REPEAT_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [CODE_W-1:0] code;
   logic              busy;
   logic              done;
   logic              led;
`ifdef LED_BLINK_CODE_REPEAT_EN
   logic              repeatReq;
`endif

   int nCompared   = 0;
   int nMismatched = 0;

   bit   mActive = 1'b0;
   int   mK      = 0;
   int   mCode   = 0;
   logic expLed  = 1'b0;
   logic expBusy = 1'b0;
   logic expDone = 1'b0;

   typedef struct {
      logic       start;
      logic [3:0] code;
      logic       led;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t vecs[20];

   always #5 clk = ~clk;

   led_blink_code #(
      .CODE_W (CODE_W),
      .ON_CYC (ON_CYC),
      .OFF_CYC(OFF_CYC),
      .GAP_CYC(GAP_CYC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .code      (code),
`ifdef LED_BLINK_CODE_REPEAT_EN
      .repeat_req(repeatReq),
`endif
      .busy      (busy),
      .done      (done),
      .led       (led)
   );

   // Single-bit comparison with failure reporting
   task checkBit(input string name, input logic act, input logic exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Integer comparison for counted properties (flash count, busy length, done timing)
   task checkInt(input string name, input int act, input int exp);
      nCompared++;
      if (act != exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Compare the DUT outputs against the model's expectation for this cycle
   task checkOutput(input string name);
      checkBit({name, ".led"},  led,  expLed);
      checkBit({name, ".busy"}, busy, expBusy);
      checkBit({name, ".done"}, done, expDone);
   endtask

   // Model: a sequence is described only by how many cycles have passed since
   // it was accepted; led/busy follow from the flash period arithmetic.
   task modelEdge(input bit s, input int c, input bit rp);
      int total;
      expDone = 1'b0;
      if (mActive) begin
         total = mCode * PERIOD + GAP_CYC;
         if (mK + 1 > total) begin
            if (REPEAT_ON && rp) begin
               mK = 1;
            end else begin
               mActive = 1'b0;
               expDone = 1'b1;
            end
         end else begin
            mK++;
         end
      end else if (s) begin
         if (c == 0) begin
            expDone = 1'b1;
         end else begin
            mActive = 1'b1;
            mK      = 1;
            mCode   = c;
         end
      end
      if (mActive) begin
         expBusy = 1'b1;
         expLed  = ((mK - 1) < mCode * PERIOD) && (((mK - 1) % PERIOD) < ON_CYC);
      end else begin
         expBusy = 1'b0;
         expLed  = 1'b0;
      end
   endtask

   task modelReset();
      mActive = 1'b0;
      mK      = 0;
      expLed  = 1'b0;
      expBusy = 1'b0;
      expDone = 1'b0;
   endtask

   // Drive one cycle of inputs, clock it, advance the model and compare
   task applyStimulus(input logic s, input logic [3:0] c, input logic rp, input string name);
      start = s;
      code  = c;
`ifdef LED_BLINK_CODE_REPEAT_EN
      repeatReq = rp;
`endif
      @(posedge clk);
      modelEdge(s, int'(c), rp);
      #1;
      checkOutput(name);
   endtask

   task doReset();
      rst = 1'b1;
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int doneAt;
      int rises;
      int busyCycles;
      int dones;
      logic prevLed;

      rst   = 1'b1;
      start = 1'b0;
      code  = '0;
`ifdef LED_BLINK_CODE_REPEAT_EN
      repeatReq = 1'b0;
`endif
      #1;
      checkBit("reset.led",  led,  1'b0);
      checkBit("reset.busy", busy, 1'b0);
      checkBit("reset.done", done, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();

      // code=1, ignored code=5 request at T+3, then a code=0 start in the done cycle
      for (int i = 0; i < 20; i++) begin
         vecs[i].start = (i == 0) || (i == 3) || (i == 18);
         vecs[i].code  = (i == 0) ? 4'd1 : ((i == 3) ? 4'd5 : 4'd0);
         vecs[i].led   = (i + 1) <= 4;
         vecs[i].busy  = (i + 1) <= 17;
         vecs[i].done  = ((i + 1) == 18) || ((i + 1) == 19);
      end
      for (int i = 0; i < 20; i++) begin
         start = vecs[i].start;
         code  = vecs[i].code;
         @(posedge clk);
         modelEdge(vecs[i].start, int'(vecs[i].code), 1'b0);
         #1;
         checkBit($sformatf("vec%0d.led", i),  led,  vecs[i].led);
         checkBit($sformatf("vec%0d.busy", i), busy, vecs[i].busy);
         checkBit($sformatf("vec%0d.done", i), done, vecs[i].done);
      end
      applyStimulus(1'b0, 4'd0, 1'b0, "settle");

      // code=2: done lands 2*7+10+1 cycles after the start edge
      doneAt = -1;
      applyStimulus(1'b1, 4'd2, 1'b0, "code2");
      for (int k = 2; k <= 27; k++) begin
         applyStimulus(1'b0, 4'd0, 1'b0, "code2");
         if (done && doneAt < 0) doneAt = k;
      end
      checkInt("code2.doneAt", doneAt, 25);

      // code=15 with noise on start/code while busy
      rises = 0; busyCycles = 0; dones = 0; prevLed = 1'b0;
      applyStimulus(1'b1, 4'd15, 1'b0, "code15");
      for (int k = 0; k < 125; k++) begin
         if (led && !prevLed) rises++;
         if (busy) busyCycles++;
         if (done) dones++;
         prevLed = led;
         applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 1'b0, "code15");
         if (!mActive && !busy) break;
      end
      if (done) dones++;
      checkInt("code15.flashes", rises, 15);
      checkInt("code15.busyLen", busyCycles, 115);
      checkInt("code15.dones", dones, 1);
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 4'd0, 1'b0, "code15.tail");

      // code=3 aborted by reset at T+6
      applyStimulus(1'b1, 4'd3, 1'b0, "abort");
      for (int k = 2; k <= 6; k++) applyStimulus(1'b0, 4'd0, 1'b0, "abort");
      rst = 1'b1;
      #1;
      checkBit("abort.asyncLed",  led,  1'b0);
      checkBit("abort.asyncBusy", busy, 1'b0);
      checkBit("abort.asyncDone", done, 1'b0);
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      dones = 0;
      for (int k = 0; k < 30; k++) begin
         applyStimulus(1'b0, 4'd0, 1'b0, "abort.quiet");
         if (done) dones++;
      end
      checkInt("abort.noDone", dones, 0);
      applyStimulus(1'b1, 4'd2, 1'b0, "abort.restart");
      for (int k = 0; k < 26; k++) applyStimulus(1'b0, 4'd0, 1'b0, "abort.restart");

`ifdef LED_BLINK_CODE_REPEAT_EN
      // code=2 repeating for three rounds, then released
      rises = 0; dones = 0; prevLed = 1'b0; doneAt = -1;
      applyStimulus(1'b1, 4'd2, 1'b1, "repeat");
      for (int k = 2; k <= 72; k++) begin
         if (led && !prevLed) rises++;
         if (done) dones++;
         prevLed = led;
         applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 1'b1, "repeat");
      end
      if (led && !prevLed) rises++;
      if (done) dones++;
      checkInt("repeat.flashes", rises, 6);
      checkInt("repeat.noDone", dones, 0);
      for (int k = 73; k <= 80; k++) begin
         applyStimulus(1'b0, 4'd0, 1'b0, "repeat.release");
         if (done && doneAt < 0) doneAt = k;
      end
      checkInt("repeat.doneAt", doneAt, 73);
`endif

      // Randomized traffic with occasional mid-sequence resets
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 599) == 0) begin
            rst = 1'b1;
            #1;
            checkBit("rand.resetLed",  led,  1'b0);
            checkBit("rand.resetBusy", busy, 1'b0);
            modelReset();
            @(posedge clk);
            #1;
            rst = 1'b0;
         end else begin
            applyStimulus(($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 4)),
                          ($urandom_range(0, 3) != 0), "rand");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
